metro_mpi_node: RTL and testbench

Parametrised, multi-channel MPI bridge node that replaces the single-channel fake node. It carries credit-based (valid/data/yummy) NoC traffic between a local tile and a remote rank. It buffers outbound flits per channel, tracks remote credits, and accumulates yummies owed to the remote side. Once per `mpi_work_i` trigger, it serialises one transmit/receive beat pair per channel over a request/acknowledge transport port served by the MPI shim.

---
 rtl/metro_mpi_node_if.sv | 31 +++
 rtl/metro_mpi_node.sv | 203 ++++++++++++++++++++
 tb/tb_metro_mpi_node.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/metro_mpi_node_if.sv
// Transport port between metro_mpi_node (master) and the MPI shim (slave):
// one transmit/receive beat pair per channel per exchange.
interface metro_mpi_node_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 4
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              tx_req_o;
  logic              tx_ack_i;
  logic [CH_W-1:0]   tx_ch_o;
  logic              tx_valid_o;
  logic [DATA_W-1:0] tx_data_o;
  logic [CNT_W-1:0]  tx_yummy_o;
  logic              rx_req_o;
  logic              rx_ack_i;
  logic              rx_valid_i;
  logic [DATA_W-1:0] rx_data_i;
  logic [CNT_W-1:0]  rx_yummy_i;

  modport master (
    output tx_req_o, tx_ch_o, tx_valid_o, tx_data_o, tx_yummy_o, rx_req_o,
    input  tx_ack_i, rx_ack_i, rx_valid_i, rx_data_i, rx_yummy_i
  );

  modport slave (
    input  tx_req_o, tx_ch_o, tx_valid_o, tx_data_o, tx_yummy_o, rx_req_o,
    output tx_ack_i, rx_ack_i, rx_valid_i, rx_data_i, rx_yummy_i
  );
endinterface

// File: rtl/metro_mpi_node.sv
// Multi-channel credit-based NoC <-> MPI bridge node. Buffers outbound flits per channel and
// serialises one tx/rx beat pair per channel for every mpi_work_i trigger.
module metro_mpi_node #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned CREDITS    = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = $clog2(CREDITS + 1)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     mpi_work_i,
  input  logic [NUM_CH-1:0]        tile_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] tile_data_i,
  output logic [NUM_CH-1:0]        tile_yummy_o,
  output logic [NUM_CH-1:0]        tile_valid_o,
  output logic [NUM_CH*DATA_W-1:0] tile_data_o,
  input  logic [NUM_CH-1:0]        tile_yummy_i,
  metro_mpi_node_if.master         mpi,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] CredMax = CNT_W'(CREDITS);

  typedef enum logic [1:0] {StIdle, StSend, StRecv, StDone} state_e;

  state_e              r_state, w_state_next;
  logic [CH_W-1:0]     r_ch, w_ch_next;
  logic                w_load_tx, w_tx_fire, w_rx_fire, w_ld_valid, w_err_set;

  logic [DATA_W-1:0]   r_fifo   [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr   [NUM_CH];
  logic [PTR_W-1:0]    r_rptr   [NUM_CH];
  logic [OCC_W-1:0]    r_occ    [NUM_CH];
  logic [CNT_W-1:0]    r_credit [NUM_CH];
  logic [CNT_W-1:0]    r_owed   [NUM_CH];

  logic [NUM_CH-1:0]   w_sel, w_full, w_push, w_pop;
  logic [CNT_W:0]      w_owed_sum [NUM_CH];
  logic [CNT_W:0]      w_cred_sum [NUM_CH];
  logic [CNT_W-1:0]    w_owed_d   [NUM_CH];
  logic [CNT_W-1:0]    w_cred_d   [NUM_CH];

  logic                r_tx_valid;
  logic [DATA_W-1:0]   r_tx_data;
  logic [CNT_W-1:0]    r_tx_yummy;
  logic [NUM_CH-1:0]   r_tile_yummy, r_tile_valid;
  logic [NUM_CH*DATA_W-1:0] r_tile_data;
  logic                r_done, r_err;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_tx_fire  = (r_state == StSend) && mpi.tx_ack_i;
  assign w_rx_fire  = (r_state == StRecv) && mpi.rx_ack_i;
  assign w_ld_valid = (r_occ[w_ch_next] != '0) && (r_credit[w_ch_next] != '0);

  always_comb begin
    w_state_next = r_state;
    w_ch_next    = r_ch;
    w_load_tx    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (mpi_work_i) begin
          w_state_next = StSend;
          w_ch_next    = '0;
          w_load_tx    = 1'b1;
        end
      end
      StSend: begin
        if (mpi.tx_ack_i) w_state_next = StRecv;
      end
      StRecv: begin
        if (mpi.rx_ack_i) begin
          if (r_ch == CH_W'(NUM_CH - 1)) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StSend;
            w_ch_next    = r_ch + 1'b1;
            w_load_tx    = 1'b1;
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
        w_ch_next    = '0;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Per-channel FIFO control and saturating credit/owed arithmetic.
  always_comb begin
    w_err_set = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_sel[c]  = (r_ch == CH_W'(c));
      w_full[c] = (r_occ[c] == OCC_W'(FIFO_DEPTH));
      w_push[c] = tile_valid_i[c] && !w_full[c];
      w_pop[c]  = w_tx_fire && r_tx_valid && w_sel[c];
      if (tile_valid_i[c] && w_full[c]) w_err_set = 1'b1;

      w_owed_sum[c] = {1'b0, r_owed[c]} + (CNT_W + 1)'(tile_yummy_i[c])
                    - ((w_tx_fire && w_sel[c]) ? {1'b0, r_tx_yummy} : '0);
      if (w_owed_sum[c] > (CNT_W + 1)'(CREDITS)) begin
        w_owed_d[c] = CredMax;
        w_err_set   = 1'b1;
      end else begin
        w_owed_d[c] = w_owed_sum[c][CNT_W-1:0];
      end

      w_cred_sum[c] = {1'b0, r_credit[c]}
                    + ((w_rx_fire && w_sel[c]) ? {1'b0, mpi.rx_yummy_i} : '0)
                    - (CNT_W + 1)'(w_pop[c]);
      if (w_cred_sum[c] > (CNT_W + 1)'(CREDITS)) begin
        w_cred_d[c] = CredMax;
        w_err_set   = 1'b1;
      end else begin
        w_cred_d[c] = w_cred_sum[c][CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_wptr[c]   <= '0;
        r_rptr[c]   <= '0;
        r_occ[c]    <= '0;
        r_credit[c] <= CredMax;
        r_owed[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_push[c]) r_wptr[c] <= ptr_inc(r_wptr[c]);
        if (w_pop[c])  r_rptr[c] <= ptr_inc(r_rptr[c]);
        r_occ[c]    <= r_occ[c] + OCC_W'(w_push[c]) - OCC_W'(w_pop[c]);
        r_credit[c] <= w_cred_d[c];
        r_owed[c]   <= w_owed_d[c];
      end
    end
  end

  // Storage needs no reset; emptiness is tracked by the occupancy counters.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_push[c]) r_fifo[c][r_wptr[c]] <= tile_data_i[c*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= StIdle;
      r_ch         <= '0;
      r_tx_valid   <= 1'b0;
      r_tx_data    <= '0;
      r_tx_yummy   <= '0;
      r_tile_yummy <= '0;
      r_tile_valid <= '0;
      r_tile_data  <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ch    <= w_ch_next;
      if (w_load_tx) begin
        r_tx_valid <= w_ld_valid;
        r_tx_data  <= w_ld_valid ? r_fifo[w_ch_next][r_rptr[w_ch_next]] : '0;
        r_tx_yummy <= r_owed[w_ch_next];
      end else if (w_tx_fire) begin
        r_tx_valid <= 1'b0;
        r_tx_data  <= '0;
        r_tx_yummy <= '0;
      end
      r_tile_yummy <= w_pop;
      r_tile_valid <= (w_rx_fire && mpi.rx_valid_i) ? w_sel : '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_rx_fire && mpi.rx_valid_i && w_sel[c]) begin
          r_tile_data[c*DATA_W +: DATA_W] <= mpi.rx_data_i;
        end
      end
      r_done <= (r_state == StDone);
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign mpi.tx_req_o   = (r_state == StSend);
  assign mpi.rx_req_o   = (r_state == StRecv);
  assign mpi.tx_ch_o    = r_ch;
  assign mpi.tx_valid_o = r_tx_valid;
  assign mpi.tx_data_o  = r_tx_data;
  assign mpi.tx_yummy_o = r_tx_yummy;
  assign tile_yummy_o   = r_tile_yummy;
  assign tile_valid_o   = r_tile_valid;
  assign tile_data_o    = r_tile_data;
  assign busy_o         = (r_state != StIdle);
  assign done_o         = r_done;
  assign err_o          = r_err;
endmodule

// File: tb/tb_metro_mpi_node.sv
// Bench for metro_mpi_node: directed scenarios plus randomised exchanges, checked against
// a transaction-level model built from per-channel queues and credit/owed counters.
module tb_metro_mpi_node;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned CREDITS    = 3;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = $clog2(CREDITS + 1);

  logic                     clk_i = 1'b0;
  logic                     rstn_i;
  logic                     mpi_work_i;
  logic [NUM_CH-1:0]        tile_valid_i;
  logic [NUM_CH*DATA_W-1:0] tile_data_i;
  logic [NUM_CH-1:0]        tile_yummy_o;
  logic [NUM_CH-1:0]        tile_valid_o;
  logic [NUM_CH*DATA_W-1:0] tile_data_o;
  logic [NUM_CH-1:0]        tile_yummy_i;
  logic                     busy_o, done_o, err_o;

  always #5 clk_i = ~clk_i;

  metro_mpi_node_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CNT_W(CNT_W)) mpi ();

  metro_mpi_node #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CREDITS(CREDITS), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .mpi_work_i(mpi_work_i),
    .tile_valid_i(tile_valid_i), .tile_data_i(tile_data_i), .tile_yummy_o(tile_yummy_o),
    .tile_valid_o(tile_valid_o), .tile_data_o(tile_data_o), .tile_yummy_i(tile_yummy_i),
    .mpi(mpi), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [DATA_W-1:0] m_q [NUM_CH][$];
  int                m_credit [NUM_CH];
  int                m_owed [NUM_CH];
  logic              m_err;
  logic [DATA_W-1:0] m_tdata [NUM_CH];

  // Receive fields for the next exchange and tx fields observed per channel
  logic              ex_rxv [NUM_CH];
  logic [DATA_W-1:0] ex_rxd [NUM_CH];
  int                ex_rxy [NUM_CH];
  logic              cap_v [NUM_CH];
  logic [DATA_W-1:0] cap_d [NUM_CH];
  int                cap_y [NUM_CH];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_q[c].delete();
      m_credit[c] = CREDITS;
      m_owed[c]   = 0;
      m_tdata[c]  = '0;
    end
    m_err = 1'b0;
  endtask

  task automatic clear_rx();
    for (int c = 0; c < NUM_CH; c++) begin
      ex_rxv[c] = 1'b0;
      ex_rxd[c] = '0;
      ex_rxy[c] = 0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".tile_yummy"}, 64'(tile_yummy_o), 64'(0));
    check_eq({tag, ".tile_valid"}, 64'(tile_valid_o), 64'(0));
    for (int c = 0; c < NUM_CH; c++)
      check_eq({tag, ".tile_data"}, tile_data_o[c*DATA_W +: DATA_W], m_tdata[c]);
    check_eq({tag, ".tx_req"},   64'(mpi.tx_req_o),   64'(0));
    check_eq({tag, ".rx_req"},   64'(mpi.rx_req_o),   64'(0));
    check_eq({tag, ".tx_ch"},    64'(mpi.tx_ch_o),    64'(0));
    check_eq({tag, ".tx_valid"}, 64'(mpi.tx_valid_o), 64'(0));
    check_eq({tag, ".tx_data"},  mpi.tx_data_o,       64'(0));
    check_eq({tag, ".tx_yummy"}, 64'(mpi.tx_yummy_o), 64'(0));
    check_eq({tag, ".busy"},     64'(busy_o),         64'(0));
    check_eq({tag, ".done"},     64'(done_o),         64'(0));
    check_eq({tag, ".err"},      64'(err_o),          64'(m_err));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    model_reset();
    check_idle_outputs("reset");
  endtask

  // One tile-side cycle in IDLE: pushes on mask v (all with data d), yummies on mask y.
  task automatic tile_cycle(input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] y,
                            input logic [DATA_W-1:0] d);
    tile_valid_i = v;
    tile_yummy_i = y;
    tile_data_i  = {NUM_CH{d}};
    @(negedge clk_i);
    tile_valid_i = '0;
    tile_yummy_i = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (v[c]) begin
        if (m_q[c].size() == FIFO_DEPTH) m_err = 1'b1;
        else m_q[c].push_back(d);
      end
      if (y[c]) begin
        if (m_owed[c] == CREDITS) m_err = 1'b1;
        else m_owed[c]++;
      end
    end
  endtask

  task automatic exchange(input int wmin, input int wmax, input bit rnd_rx);
    logic              exp_v;
    logic [DATA_W-1:0] exp_d;
    int                exp_y, w, sum;
    if (rnd_rx) begin
      for (int c = 0; c < NUM_CH; c++) begin
        ex_rxv[c] = 1'($urandom_range(1, 0));
        ex_rxd[c] = {$urandom, $urandom};
        ex_rxy[c] = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0))
                                                 : int'($urandom_range(1, 0));
      end
    end
    mpi_work_i = 1'b1;
    @(negedge clk_i);
    mpi_work_i = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_v = (m_q[c].size() > 0) && (m_credit[c] > 0);
      exp_d = exp_v ? m_q[c][0] : '0;
      exp_y = m_owed[c];
      cap_v[c] = mpi.tx_valid_o;
      cap_d[c] = mpi.tx_data_o;
      cap_y[c] = int'(mpi.tx_yummy_o);
      w = int'($urandom_range(wmax, wmin));
      for (int s = 0; s <= w; s++) begin
        check_eq("send.tx_req",   64'(mpi.tx_req_o),   64'(1));
        check_eq("send.rx_req",   64'(mpi.rx_req_o),   64'(0));
        check_eq("send.tx_ch",    64'(mpi.tx_ch_o),    64'(c));
        check_eq("send.tx_valid", 64'(mpi.tx_valid_o), 64'(exp_v));
        check_eq("send.tx_data",  mpi.tx_data_o,       exp_d);
        check_eq("send.tx_yummy", 64'(mpi.tx_yummy_o), 64'(exp_y));
        if (s < w) begin
          mpi.rx_ack_i = 1'($urandom_range(1, 0));  // must be ignored outside RECV
          @(negedge clk_i);
          mpi.rx_ack_i = 1'b0;
        end
      end
      mpi.tx_ack_i = 1'b1;
      @(negedge clk_i);
      mpi.tx_ack_i = 1'b0;
      if (exp_v) begin
        void'(m_q[c].pop_front());
        m_credit[c]--;
      end
      m_owed[c] -= exp_y;
      check_eq("tile_yummy_pulse", 64'(tile_yummy_o), exp_v ? (64'(1) << c) : 64'(0));
      w = int'($urandom_range(wmax, wmin));
      for (int s = 0; s <= w; s++) begin
        check_eq("recv.rx_req", 64'(mpi.rx_req_o), 64'(1));
        check_eq("recv.tx_req", 64'(mpi.tx_req_o), 64'(0));
        check_eq("recv.tx_ch",  64'(mpi.tx_ch_o),  64'(c));
        if (s > 0) check_eq("recv.tile_yummy", 64'(tile_yummy_o), 64'(0));
        if (s < w) begin
          mpi.tx_ack_i = 1'($urandom_range(1, 0));  // must be ignored outside SEND
          @(negedge clk_i);
          mpi.tx_ack_i = 1'b0;
        end
      end
      mpi.rx_ack_i   = 1'b1;
      mpi.rx_valid_i = ex_rxv[c];
      mpi.rx_data_i  = ex_rxd[c];
      mpi.rx_yummy_i = CNT_W'(ex_rxy[c]);
      @(negedge clk_i);
      mpi.rx_ack_i   = 1'b0;
      mpi.rx_valid_i = 1'b0;
      mpi.rx_data_i  = '0;
      mpi.rx_yummy_i = '0;
      sum = m_credit[c] + ex_rxy[c];
      if (sum > CREDITS) begin
        m_err = 1'b1;
        sum   = CREDITS;
      end
      m_credit[c] = sum;
      if (ex_rxv[c]) m_tdata[c] = ex_rxd[c];
      check_eq("tile_valid_pulse", 64'(tile_valid_o), ex_rxv[c] ? (64'(1) << c) : 64'(0));
      check_eq("tile_data", tile_data_o[c*DATA_W +: DATA_W], m_tdata[c]);
      check_eq("recv_end.tile_yummy", 64'(tile_yummy_o), 64'(0));
    end
    check_eq("done_state.busy", 64'(busy_o), 64'(1));
    check_eq("done_state.done", 64'(done_o), 64'(0));
    @(negedge clk_i);
    check_eq("done_pulse", 64'(done_o), 64'(1));
    check_eq("done.busy",  64'(busy_o), 64'(0));
    check_eq("done.err",   64'(err_o),  64'(m_err));
    check_eq("done.tile_valid", 64'(tile_valid_o), 64'(0));
  endtask

  initial begin
    rstn_i         = 1'b0;
    mpi_work_i     = 1'b0;
    tile_valid_i   = '0;
    tile_yummy_i   = '0;
    tile_data_i    = '0;
    mpi.tx_ack_i   = 1'b0;
    mpi.rx_ack_i   = 1'b0;
    mpi.rx_valid_i = 1'b0;
    mpi.rx_data_i  = '0;
    mpi.rx_yummy_i = '0;
    clear_rx();
    model_reset();

    // Reset, then an empty exchange with zero-wait acks
    do_reset();
    exchange(0, 0, 0);
    for (int c = 0; c < NUM_CH; c++) begin
      check_eq("empty.tx_valid", 64'(cap_v[c]), 64'(0));
      check_eq("empty.tx_yummy", 64'(cap_y[c]), 64'(0));
    end

    // Single flit on ch1
    tile_cycle(3'b010, 3'b000, 64'hDEAD_BEEF);
    exchange(0, 0, 0);
    check_eq("single.valid", 64'(cap_v[1]), 64'(1));
    check_eq("single.data",  cap_d[1], 64'hDEAD_BEEF);

    // Credit exhaustion on ch0
    for (int i = 0; i < 4; i++) tile_cycle(3'b001, 3'b000, 64'hA0 + 64'(i));
    for (int i = 0; i < 4; i++) begin
      exchange(0, 0, 0);
      check_eq("exhaust.valid", 64'(cap_v[0]), (i < 3) ? 64'(1) : 64'(0));
    end
    ex_rxy[0] = 1;
    exchange(0, 0, 0);
    check_eq("exhaust.still_blocked", 64'(cap_v[0]), 64'(0));
    clear_rx();
    exchange(0, 0, 0);
    check_eq("exhaust.resume_valid", 64'(cap_v[0]), 64'(1));
    check_eq("exhaust.resume_data",  cap_d[0], 64'hA3);

    // Inbound flit on ch2, then yummies owed back to the remote
    ex_rxv[2] = 1'b1;
    ex_rxd[2] = 64'h1234;
    exchange(0, 0, 0);
    check_eq("inbound.data", tile_data_o[2*DATA_W +: DATA_W], 64'h1234);
    clear_rx();
    tile_cycle(3'b000, 3'b100, '0);
    tile_cycle(3'b000, 3'b100, '0);
    exchange(0, 0, 0);
    check_eq("owed.first",  64'(cap_y[2]), 64'(2));
    exchange(0, 0, 0);
    check_eq("owed.second", 64'(cap_y[2]), 64'(0));

    // Backpressure: five stall cycles on every ack
    tile_cycle(3'b100, 3'b000, 64'h5555_AAAA_0F0F_F0F0);
    exchange(5, 5, 0);

    // Reset while waiting in RECV
    tile_cycle(3'b001, 3'b000, 64'h77);
    mpi_work_i = 1'b1;
    @(negedge clk_i);
    mpi_work_i   = 1'b0;
    mpi.tx_ack_i = 1'b1;
    @(negedge clk_i);
    mpi.tx_ack_i = 1'b0;
    check_eq("midrst.in_recv", 64'(mpi.rx_req_o), 64'(1));
    #1 rstn_i = 1'b0;
    #1;
    check_eq("midrst.busy",   64'(busy_o),       64'(0));
    check_eq("midrst.rx_req", 64'(mpi.rx_req_o), 64'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      check_eq("midrst.tile_yummy", 64'(tile_yummy_o), 64'(0));
      check_eq("midrst.tile_valid", 64'(tile_valid_o), 64'(0));
    end
    rstn_i = 1'b1;
    model_reset();
    check_idle_outputs("midrst");
    for (int i = 0; i < 3; i++) tile_cycle(3'b010, 3'b000, 64'hC0 + 64'(i));
    for (int i = 0; i < 3; i++) exchange(0, 0, 0);
    check_eq("midrst.credit_restored", 64'(cap_v[1]), 64'(1));

    // Credit overflow from the remote
    do_reset();
    ex_rxy[1] = 1;
    exchange(0, 0, 0);
    check_eq("credit_ovf.err", 64'(err_o), 64'(1));
    clear_rx();
    tile_cycle(3'b000, 3'b000, '0);
    check_eq("credit_ovf.sticky", 64'(err_o), 64'(1));

    // FIFO overflow: the fifth push is dropped
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tile_cycle(3'b001, 3'b000, 64'hF0 + 64'(i));
      check_eq("fifo_ovf.err", 64'(err_o), (i == 4) ? 64'(1) : 64'(0));
    end
    ex_rxy[0] = 1;
    for (int i = 0; i < 5; i++) begin
      exchange(0, 0, 0);
      if (i == 3) check_eq("fifo_ovf.last_kept", cap_d[0], 64'hF3);
    end
    check_eq("fifo_ovf.dropped", 64'(cap_v[0]), 64'(0));
    clear_rx();

    // Randomised traffic
    do_reset();
    for (int it = 0; it < 40; it++) begin
      for (int k = int'($urandom_range(3, 0)); k > 0; k--) begin
        logic [NUM_CH-1:0] v, y;
        for (int c = 0; c < NUM_CH; c++) begin
          v[c] = 1'($urandom_range(1, 0));
          y[c] = ($urandom_range(3, 0) == 0);
        end
        tile_cycle(v, y, {$urandom, $urandom});
      end
      exchange(0, 2, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
